// File: rtl/led_indicator.sv
// led_indicator: UART byte capture shown on LEDs as bits/count/activity/digit; leds update on the strobe edge, no backpressure.
// Optional idle blink is compiled in with INDICATOR_BLINK_EN.
module led_indicator #(
    parameter int DATA_W      = 8,
    parameter int LED_COUNT   = 5,
    parameter int HOLD_CYCLES = 8,
    parameter int IDLE_CYCLES = 16,
    parameter int BLINK_HALF  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data,
    input  logic                 ready,
    input  logic [1:0]           mode,
    output logic [LED_COUNT-1:0] leds
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        MODE_BITS  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_ACT   = 2'd2,
        MODE_DIGIT = 2'd3
    } mode_e;

    if (DATA_W < 4 || LED_COUNT < 2 || LED_COUNT > DATA_W || HOLD_CYCLES < 1 ||
        IDLE_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_param
        $error("led_indicator: illegal parameter combination");
    end

    logic [DATA_W-1:0]    last, last_n;
    logic                 prev_valid;
    logic [LED_COUNT-1:0] cnt, cnt_n;
    logic [HW-1:0]        act, act_n, rep, rep_n;
    logic                 armed;
    logic                 strobe, repeat_hit;
    logic [31:0]          last_w;
    logic [LED_COUNT-1:0] disp;

    // armed stays low until the first edge after reset release, so a strobe on that edge is dropped
    always_comb begin
        strobe     = ready & armed;
        repeat_hit = strobe & prev_valid & (data == last);
        last_n     = strobe ? data : last;
        cnt_n      = strobe ? cnt + LED_COUNT'(1) : cnt;
        act_n      = strobe ? HOLD : ((act != '0) ? act - HW'(1) : '0);
        rep_n      = repeat_hit ? HOLD : ((rep != '0) ? rep - HW'(1) : '0);
        last_w     = 32'(last_n);
        disp       = '0;
        case (mode_e'(mode))
            MODE_BITS:  disp = last_n[LED_COUNT-1:0];
            MODE_COUNT: disp = cnt_n;
            MODE_ACT: begin
                disp[0] = (act_n != '0);
                disp[1] = (rep_n != '0);
            end
            MODE_DIGIT: begin
                if (last_w >= 32'h30 && last_w <= 32'h39)
                    disp = LED_COUNT'(last_w - 32'h30);
                else
                    disp = '1;
            end
            default: disp = '0;
        endcase
    end

`ifdef INDICATOR_BLINK_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [IW-1:0] idle, idle_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n, idle_sat;

    always_comb begin
        idle_sat = (idle == IW'(IDLE_CYCLES));
        idle_n   = idle;
        bcnt_n   = bcnt;
        phase_n  = phase;
        if (strobe) begin
            idle_n  = '0;
            bcnt_n  = '0;
            phase_n = 1'b1;
        end else if (!idle_sat) begin
            idle_n = idle + IW'(1);
        end else if (bcnt == BW'(BLINK_HALF - 1)) begin
            bcnt_n  = '0;
            phase_n = ~phase;
        end else begin
            bcnt_n = bcnt + BW'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last       <= '0;
            prev_valid <= 1'b0;
            cnt        <= '0;
            act        <= '0;
            rep        <= '0;
            armed      <= 1'b0;
            leds       <= '0;
`ifdef INDICATOR_BLINK_EN
            idle       <= '0;
            bcnt       <= '0;
            phase      <= 1'b1;  // lit, so output is steady until the idle timeout
`endif
        end else begin
            armed      <= 1'b1;
            last       <= last_n;
            prev_valid <= prev_valid | strobe;
            cnt        <= cnt_n;
            act        <= act_n;
            rep        <= rep_n;
`ifdef INDICATOR_BLINK_EN
            idle       <= idle_n;
            bcnt       <= bcnt_n;
            phase      <= phase_n;
            leds       <= disp & {LED_COUNT{phase_n}};
`else
            leds       <= disp;
`endif
        end
    end

endmodule
